// File: rtl/dense_pkg.sv
`default_nettype none
// dense_pkg: shared state encoding and word type for the dense-layer sequencer.
package dense_pkg;

  localparam int N_DEF     = 40;
  localparam int FRAC_BITS = 11;

  typedef logic signed [N_DEF-1:0] word_t;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/dense_layer_seq.sv
`default_nettype none
// dense_layer_seq: streams a W-element vector into mat_mul over the done/flag
// handshake and replays the W results as a downstream valid/ready stream.
module dense_layer_seq
  import dense_pkg::*;
#(
  parameter int N      = 40,
  parameter int W      = 16,
  parameter int SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic signed [N-1:0]   in_data_i,
  output logic [W-1:0][N-1:0]   vec_o,
  output logic                  done_o,
  input  logic                  flag_i,
  input  logic [W-1:0][N-1:0]   res_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic signed [N-1:0]   out_data_o,
  output logic                  out_last_o,
  output logic                  busy_o
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

  seq_state_t               state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     done_q, done_d;
  logic [W-1:0][N-1:0]      vec_q;
  logic [W-1:0][N-1:0]      resreg_q;
  logic                     in_hs, cap;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    in_hs   = 1'b0;
    cap     = 1'b0;
    case (state_q)
      LOAD: begin
        if (in_valid_i) begin
          in_hs = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
            state_d = COMPUTE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      COMPUTE: begin
        // flag is only trusted once mat_mul has had SETTLE cycles to settle
        if (cnt_q != SETTLE_C) begin
          cnt_d = cnt_q + 1'b1;
        end else if (flag_i) begin
          cap     = 1'b1;
          done_d  = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready_i) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = LOAD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = LOAD;
        idx_d   = '0;
        cnt_d   = '0;
        done_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LOAD;
      idx_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b1;
      vec_q    <= '0;
      resreg_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      if (in_hs) vec_q[idx_q] <= in_data_i;
      if (cap)   resreg_q     <= res_i;
    end
  end

  assign in_ready_o  = (state_q == LOAD);
  assign done_o      = done_q;
  assign vec_o       = vec_q;
  assign out_valid_o = (state_q == DRAIN);
  assign out_data_o  = out_valid_o ? resreg_q[idx_q] : '0;
  assign out_last_o  = out_valid_o && (idx_q == LAST_IDX);
  assign busy_o      = !((state_q == LOAD) && (idx_q == '0));

endmodule
`default_nettype wire

// File: tb/tb_dense_layer_seq.sv
`default_nettype none
// tb_dense_layer_seq: directed bench pairing the sequencer with a behavioural
// mat_mul (relu((mat1 * vec) >>> 11 + bias)).
module tb_dense_layer_seq;

  localparam int N = 40;
  localparam int W = 4;
  localparam int SETTLE = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic signed [N-1:0] in_data;
  logic [W-1:0][N-1:0] vec;
  logic                done;
  logic                flag;
  logic [W-1:0][N-1:0] res;
  logic                out_valid;
  logic                out_ready;
  logic signed [N-1:0] out_data;
  logic                out_last;
  logic                busy;

  longint              mat1 [W][W];
  longint              bias [W];
  logic                flag_en;
  logic signed [N-1:0] exp_v [W];
  int                  n_cmp = 0;
  int                  n_err = 0;

  dense_layer_seq #(.N(N), .W(W), .SETTLE(SETTLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .vec_o      (vec),
    .done_o     (done),
    .flag_i     (flag),
    .res_i      (res),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_last_o (out_last),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  assign flag = !done && flag_en;

  always_comb begin : mm_model
    longint acc;
    for (int i = 0; i < W; i++) begin
      acc = 0;
      for (int j = 0; j < W; j++) acc += mat1[i][j] * longint'($signed(vec[j]));
      acc = (acc >>> 11) + bias[i];
      res[i] = (acc < 0) ? '0 : acc[N-1:0];
    end
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_layer(input longint b);
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) mat1[i][j] = (i == j) ? 64'sd2048 : 64'sd0;
      bias[i] = b;
    end
  endtask

  // Pushes one element per call, then idles `gap` cycles; starts and ends on a negedge.
  task automatic push(input longint v, input int gap);
    int g = 0;
    in_valid = 1'b1;
    in_data  = v[N-1:0];
    while (!in_ready && g < 100) begin @(negedge clk); g++; end
    if (!in_ready) chk_eq("push_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < gap; k++) @(negedge clk);
  endtask

  task automatic wait_out(output int dlow, output int cyc);
    dlow = 0; cyc = 0;
    while (!out_valid && cyc < 200) begin
      if (!done) dlow++;
      @(negedge clk);
      cyc++;
    end
    if (!out_valid) chk_eq("wait_out_timeout", 0, 1);
  endtask

  // Collects nmax results; bp selects out_ready pattern 1,0,0,1,... with hold checks.
  task automatic drain(input int nmax, input bit bp);
    int k = 0, cyc = 0;
    logic [N-1:0] pd = '0;
    logic pl = 1'b0;
    bit stalled = 1'b0;
    while (k < nmax && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (stalled && out_valid) begin
        chk_eq("hold_data", out_data, pd);
        chk_eq("hold_last", out_last, pl);
      end
      out_ready = bp ? ((cyc % 4 == 1) || (cyc % 4 == 0)) : 1'b1;
      if (out_valid) begin
        pd = out_data;
        pl = out_last;
        stalled = !out_ready;
        if (out_ready) begin
          chk_eq($sformatf("data%0d", k), out_data, exp_v[k]);
          chk_eq($sformatf("last%0d", k), out_last, (k == W-1));
          k++;
        end
      end else begin
        stalled = 1'b0;
      end
    end
    chk_eq("drain_count", k, nmax);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int dlow, cyc;
    bit bad;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flag_en = 1'b1;
    set_layer(0);
    repeat (2) @(negedge clk);
    chk_eq("rst_done", done, 1);
    chk_eq("rst_in_ready", in_ready, 1);
    chk_eq("rst_out_valid", out_valid, 0);
    chk_eq("rst_out_last", out_last, 0);
    chk_eq("rst_out_data", out_data, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_vec", vec, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: identity pass-through, latency and done-low width
    push(10, 0); push(20, 0); push(30, 0); push(40, 0);
    wait_out(dlow, cyc);
    chk_eq("t1_done_low", dlow, SETTLE + 1);
    chk_eq("t1_latency", cyc + 1, SETTLE + 2);
    exp_v = '{10, 20, 30, 40};
    drain(W, 1'b0);
    chk_eq("t1_in_ready", in_ready, 1);
    chk_eq("t1_busy", busy, 0);
    chk_eq("t1_out_valid", out_valid, 0);
    for (int i = 0; i < W; i++) chk_eq($sformatf("t1_vec%0d", i), vec[i], (i + 1) * 10);

    // 2: bias -25 with ReLU
    set_layer(-25);
    push(10, 0); push(20, 0); push(30, 0); push(40, 0);
    wait_out(dlow, cyc);
    exp_v = '{0, 0, 5, 15};
    drain(W, 1'b0);

    // 3: downstream backpressure
    set_layer(0);
    push(100, 0); push(200, 0); push(300, 0); push(400, 0);
    wait_out(dlow, cyc);
    exp_v = '{100, 200, 300, 400};
    drain(W, 1'b1);
    chk_eq("t3_in_ready", in_ready, 1);

    // 4: upstream gaps, COMPUTE only after the 4th handshake
    push(1, 2); push(2, 2); push(3, 1);
    chk_eq("t4_in_ready_pre", in_ready, 1);
    chk_eq("t4_done_pre", done, 1);
    chk_eq("t4_busy_pre", busy, 1);
    push(4, 0);
    chk_eq("t4_done_post", done, 0);
    chk_eq("t4_in_ready_post", in_ready, 0);
    for (int i = 0; i < W; i++) chk_eq($sformatf("t4_vec%0d", i), vec[i], i + 1);
    wait_out(dlow, cyc);
    exp_v = '{1, 2, 3, 4};
    drain(W, 1'b0);

    // 5: flag withheld for 50 cycles
    flag_en = 1'b0;
    push(5, 0); push(6, 0); push(7, 0); push(8, 0);
    bad = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (done !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    chk_eq("t5_stall_hold", bad, 0);
    flag_en = 1'b1;
    @(negedge clk);
    chk_eq("t5_release_valid", out_valid, 1);
    chk_eq("t5_release_done", done, 1);
    exp_v = '{5, 6, 7, 8};
    drain(W, 1'b0);

    // 6: reset mid-DRAIN after two results, then a clean vector
    push(11, 0); push(12, 0); push(13, 0); push(14, 0);
    wait_out(dlow, cyc);
    exp_v = '{11, 12, 13, 14};
    drain(2, 1'b0);
    chk_eq("t6_pre_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk_eq("t6_rst_valid", out_valid, 0);
    chk_eq("t6_rst_done", done, 1);
    chk_eq("t6_rst_in_ready", in_ready, 1);
    chk_eq("t6_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push(21, 0); push(22, 0); push(23, 0); push(24, 0);
    wait_out(dlow, cyc);
    chk_eq("t6_done_low", dlow, SETTLE + 1);
    exp_v = '{21, 22, 23, 24};
    drain(W, 1'b0);
    chk_eq("t6_in_ready", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
